// File: rtl/operand_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the operand sequencer and its timer.
//   WORD_W : operand / result word width
//   N_OPS  : number of operands assembled per datapath transaction
//   TMR_W  : width of the saturating WAIT-state timer
//   CNT_W  : width of the operand slot index
//   seq_state_e : sequencer states (COLLECT, START, WAIT, OUT)
//   is_last_slot : true when the slot index addresses the final operand
// ---------------------------------------------------------------------------
package seq_pkg;

    localparam int WORD_W = 32;
    localparam int N_OPS  = 4;
    localparam int TMR_W  = 16;
    localparam int CNT_W  = 2;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_OUT     = 2'd3
    } seq_state_e;

    // The final operand's handshake is what closes a batch.
    function automatic logic is_last_slot(input logic [CNT_W-1:0] slot);
        return (slot == CNT_W'(N_OPS - 1));
    endfunction

endpackage

// File: rtl/operand_sequencer_timer.sv
// ---------------------------------------------------------------------------
// seq_timer
// Clear/enable saturating cycle counter used to bound the WAIT state.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   clear   : force count to zero (has priority over enable)
//   enable  : advance count by one, saturating at all-ones
//   expired : count currently equals TIMEOUT-1
// ---------------------------------------------------------------------------
module seq_timer
    import seq_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] SAT   = {TMR_W{1'b1}};

    logic [TMR_W-1:0] count_r;

    // Saturating counter; never wraps back to zero on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {TMR_W{1'b0}};
        end else if (clear) begin
            count_r <= {TMR_W{1'b0}};
        end else if (enable && (count_r != SAT)) begin
            count_r <= count_r + {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LIMIT);

endmodule

// File: rtl/operand_sequencer.sv
// ---------------------------------------------------------------------------
// operand_sequencer
// Collects four 32-bit operands from a valid/ready stream, presents them on
// the parallel x1..x4 bus, pulses start, waits for done (bounded by TIMEOUT)
// and returns the result (or a timeout error) over a valid/ready stream.
//   clk, rst              : clock and synchronous active-high reset
//   in_valid/in_ready     : operand stream handshake
//   in_data               : operand word (1st -> x1 ... 4th -> x4)
//   x1..x4                : operand bus, changes only on operand handshakes
//   start                 : one-cycle datapath kick
//   done, result          : datapath completion and result (WAIT only)
//   out_valid/out_ready   : result stream handshake
//   out_data, out_err     : captured result, or 0 with out_err=1 on timeout
//   busy                  : high whenever not collecting operands
// ---------------------------------------------------------------------------
module operand_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic [WORD_W-1:0] x1,
    output logic [WORD_W-1:0] x2,
    output logic [WORD_W-1:0] x3,
    output logic [WORD_W-1:0] x4,
    output logic              start,
    input  logic              done,
    input  logic [WORD_W-1:0] result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_err,
    output logic              busy
);

    seq_state_e        state_r;
    seq_state_e        state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [WORD_W-1:0] slot_r [N_OPS];
    logic [WORD_W-1:0] out_data_r;
    logic              out_err_r;
    logic              in_ready_r;
    logic              start_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              accept_s;
    logic              expired_s;
    logic              tmr_clear_s;
    logic              tmr_en_s;

    // Acceptance depends only on in_valid and the state register.
    assign accept_s    = in_valid && (state_r == ST_COLLECT);
    assign tmr_clear_s = (state_r == ST_START);
    assign tmr_en_s    = (state_r == ST_WAIT) && !done;

    seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear_s),
        .enable  (tmr_en_s),
        .expired (expired_s)
    );

    // Next-state logic; done wins over timer expiry in the same WAIT cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_COLLECT: begin
                if (accept_s && is_last_slot(cnt_r)) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_START: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    state_s = ST_OUT;
                end else if (expired_s) begin
                    state_s = ST_OUT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_s = ST_COLLECT;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_COLLECT;
            end
        endcase
    end

    // State register plus the handshake/strobe flags registered from the
    // next state so they are pure flop outputs aligned with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_COLLECT;
            in_ready_r  <= 1'b1;
            start_r     <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == ST_COLLECT);
            start_r     <= (state_s == ST_START);
            out_valid_r <= (state_s == ST_OUT);
            busy_r      <= (state_s != ST_COLLECT);
        end
    end

    // Operand slots; the 2-bit index naturally wraps 3->0 on the last
    // handshake, which is exactly the COLLECT->START transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
            for (int i = 0; i < N_OPS; i++) begin
                slot_r[i] <= {WORD_W{1'b0}};
            end
        end else if (accept_s) begin
            cnt_r         <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            slot_r[cnt_r] <= in_data;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Result capture: done in WAIT latches the datapath result, timer
    // expiry without done reports a zero word flagged as an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r <= {WORD_W{1'b0}};
            out_err_r  <= 1'b0;
        end else if (state_r == ST_WAIT) begin
            if (done) begin
                out_data_r <= result;
                out_err_r  <= 1'b0;
            end else if (expired_s) begin
                out_data_r <= {WORD_W{1'b0}};
                out_err_r  <= 1'b1;
            end else begin
                out_data_r <= out_data_r;
                out_err_r  <= out_err_r;
            end
        end else begin
            out_data_r <= out_data_r;
            out_err_r  <= out_err_r;
        end
    end

    assign x1        = slot_r[0];
    assign x2        = slot_r[1];
    assign x3        = slot_r[2];
    assign x4        = slot_r[3];
    assign in_ready  = in_ready_r;
    assign start     = start_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = out_data_r;
    assign out_err   = out_err_r;

endmodule

// File: tb/tb_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_operand_sequencer
// Self-checking bench for operand_sequencer (TIMEOUT=8). Expected results
// are pushed to a scoreboard queue when a batch is issued and popped when
// the DUT presents its output.
// ---------------------------------------------------------------------------
module tb_operand_sequencer;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] x1, x2, x3, x4;
    logic        start;
    logic        done;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int xfers = 0;
    int exp_xfers = 0;
    logic [32:0] sb [$];

    operand_sequencer #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .x4        (x4),
        .start     (start),
        .done      (done),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Count output transfers independently of the scoreboard.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) xfers <= xfers + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0][31:0] pk(input logic [31:0] a, b, c, d);
        logic [3:0][31:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    task automatic check_reset();
        check_eq("rst_in_ready",  in_ready,  64'd1);
        check_eq("rst_out_valid", out_valid, 64'd0);
        check_eq("rst_start",     start,     64'd0);
        check_eq("rst_busy",      busy,      64'd0);
        check_eq("rst_out_data",  out_data,  64'd0);
        check_eq("rst_out_err",   out_err,   64'd0);
        check_eq("rst_x", {x1 | x2 | x3 | x4}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; done = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_reset();
        sb.delete();
    endtask

    // Offer n operands; idle gaps between them (not after the 4th).
    task automatic feed_ops(input logic [3:0][31:0] ops, input int n, input int gap,
                            input logic done_lvl);
        int w;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_data = ops[i];
            done = done_lvl; result = 32'hDEAD_0000 + i;
            w = 0;
            while (!in_ready && w < 50) begin @(negedge clk); w++; end
            if (w >= 50) check_eq("in_ready_wait", 64'd0, 64'd1);
            @(negedge clk);
            in_valid = 1'b0; in_data = 32'h0;
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    check_eq("collect_ready", in_ready, 64'd1);
                    check_eq("collect_noout", out_valid, 64'd0);
                    @(negedge clk);
                end
            end
        end
        done = 1'b0;
    endtask

    // One full batch. dd = WAIT cycle index (0 = first) carrying done; dd<0 never.
    task automatic run_batch(input logic [3:0][31:0] ops, input int gap, input int dd,
                             input logic [31:0] res, input int hold,
                             input logic done_collect, input logic done_start);
        int k;
        int exp_lat;
        logic [32:0] e;
        feed_ops(ops, 4, gap, done_collect);
        check_eq("start_pulse", start, 64'd1);
        check_eq("start_noready", in_ready, 64'd0);
        check_eq("start_busy", busy, 64'd1);
        check_eq("x1", x1, ops[0]);
        check_eq("x2", x2, ops[1]);
        check_eq("x3", x3, ops[2]);
        check_eq("x4", x4, ops[3]);
        if (dd >= 0 && dd < TO) begin
            sb.push_back({1'b0, res});
            exp_lat = dd + 1;
        end else begin
            sb.push_back({1'b1, 32'h0});
            exp_lat = TO;
        end
        done = done_start; result = 32'hBAD0_BAD0;
        @(negedge clk);
        done = 1'b0;
        check_eq("start_once", start, 64'd0);
        k = 0;
        while (!out_valid && k < 40) begin
            done   = (k == dd);
            result = (k == dd) ? res : 32'hBAD0_BAD0;
            @(negedge clk);
            k++;
        end
        done = 1'b0;
        check_eq("latency", k, exp_lat);
        check_eq("x_hold", {x1, x4}, {ops[0], ops[3]});
        if (sb.size() == 0) begin
            check_eq("sb_empty", 64'd0, 64'd1);
            e = 33'h0;
        end else begin
            e = sb.pop_front();
        end
        for (int h = 0; h < hold; h++) begin
            done = 1'b1; result = 32'h5555_AAAA;
            check_eq("hold_valid", out_valid, 64'd1);
            check_eq("hold_data", {out_err, out_data}, e);
            @(negedge clk);
        end
        done = 1'b0;
        out_ready = 1'b1;
        check_eq("out_valid", out_valid, 64'd1);
        check_eq("out_data", out_data, e[31:0]);
        check_eq("out_err", out_err, e[32]);
        @(negedge clk);
        out_ready = 1'b0;
        exp_xfers++;
        check_eq("post_ready", in_ready, 64'd1);
        check_eq("post_novalid", out_valid, 64'd0);
        check_eq("post_busy", busy, 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0;
        done = 1'b0; result = 32'h0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset();

        // Basic: 5,9,2,7, done three cycles after start.
        run_batch(pk(32'd5, 32'd9, 32'd2, 32'd7), 0, 2, 32'h9, 0, 1'b0, 1'b0);
        // Gaps and output back-pressure.
        run_batch(pk(32'h11, 32'h22, 32'h33, 32'h44), 3, 1, 32'hCAFE_F00D, 10, 1'b0, 1'b0);
        // Timeout, then a normal batch.
        run_batch(pk(32'h1, 32'h2, 32'h3, 32'h4), 0, -1, 32'h0, 2, 1'b0, 1'b0);
        run_batch(pk(32'hA, 32'hB, 32'hC, 32'hD), 0, 0, 32'h1234_5678, 0, 1'b0, 1'b0);
        // done asserted in COLLECT and in the START cycle.
        run_batch(pk(32'h100, 32'h200, 32'h300, 32'h400), 2, 1, 32'h77, 1, 1'b1, 1'b1);
        // done coincides with timer expiry.
        run_batch(pk(32'hF1, 32'hF2, 32'hF3, 32'hF4), 0, TO - 1, 32'hABCD_EF01, 0, 1'b0, 1'b0);

        // Reset after two operands.
        feed_ops(pk(32'hE1, 32'hE2, 32'h0, 32'h0), 2, 0, 1'b0);
        do_reset();
        run_batch(pk(32'h21, 32'h22, 32'h23, 32'h24), 0, 3, 32'h2222, 0, 1'b0, 1'b0);
        // Reset while in WAIT.
        feed_ops(pk(32'h31, 32'h32, 32'h33, 32'h34), 4, 0, 1'b0);
        repeat (2) @(negedge clk);
        do_reset();
        run_batch(pk(32'h41, 32'h42, 32'h43, 32'h44), 1, 0, 32'h4444, 0, 1'b0, 1'b0);
        // Reset with out_valid pending.
        feed_ops(pk(32'h51, 32'h52, 32'h53, 32'h54), 4, 0, 1'b0);
        @(negedge clk);
        done = 1'b1; result = 32'h5151;
        @(negedge clk);
        done = 1'b0;
        check_eq("pend_valid", out_valid, 64'd1);
        do_reset();
        run_batch(pk(32'h61, 32'h62, 32'h63, 32'h64), 0, 2, 32'h6666, 3, 1'b0, 1'b0);

        // A few randomised batches.
        for (int r = 0; r < 4; r++) begin
            run_batch(pk($urandom, $urandom, $urandom, $urandom),
                      $urandom_range(0, 2), $urandom_range(0, 5), $urandom,
                      $urandom_range(0, 3), 1'b0, 1'b0);
        end

        repeat (2) @(negedge clk);
        check_eq("xfer_count", xfers, exp_xfers);
        check_eq("sb_drained", sb.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Front-end initiator for the four-operand compute datapath. It accepts 32-bit operands one at a time over a valid/ready stream and assembles them into the parallel `x1..x4` bus. It then issues a one-cycle `start` and waits for `done`. The datapath `Result` is returned over a valid/ready output stream, and a bounded timeout reports a hung datapath instead of stalling the stream.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in WAIT before aborting; legal range 2..65535.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand word offered.
- `in_ready`  out  1  sequencer can accept an operand.
- `in_data`  in  32  operand word; first accepted maps to `x1`, fourth to `x4`.
- `x1`, `x2`, `x3`, `x4`  out  32 each  operand bus to datapath; stable from START through the end of WAIT.
- `start`  out  1  one-cycle pulse; datapath loads operands and begins.
- `done`  in  1  datapath completion; sampled only in WAIT.
- `result`  in  32  datapath result; valid in the cycle `done`=1.
- `out_valid`  out  1  result word available.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  32  captured result, or 0 on timeout.
- `out_err`  out  1  qualifies `out_data`; 1 = timeout abort.
- `busy`  out  1  high in every state except COLLECT.

## Operation
- States: COLLECT, START, WAIT, OUT.
- COLLECT
  - `in_ready`=1. Each `in_valid && in_ready` writes `in_data` into slot `cnt` (0..3), then `cnt` increments.
  - The handshake at `cnt`=3 moves to START and clears `cnt` to 0.
- START
  - `start`=1 for exactly one cycle; `in_ready`=0.
  - `done` is ignored. Next state is WAIT and `tmr` is cleared.
- WAIT
  - If `done`=1: capture `result` into `out_data`, set `out_err`=0, go to OUT.
  - Otherwise `tmr` increments. At `tmr`=TIMEOUT-1 with no `done`: set `out_data`=0, `out_err`=1, go to OUT.
  - `done` takes priority over timeout in the same cycle.
- OUT
  - `out_valid`=1; `out_data` and `out_err` are held.
  - On `out_valid && out_ready`, go to COLLECT.
- `done` outside WAIT is ignored; no latching and no error.
- `x1..x4` change only on COLLECT handshakes, so slots not yet overwritten keep their previous operand values.
- Width rules:
  - `cnt` is 2 bits and wraps 3→0 only via the START transition.
  - `tmr` is 16 bits, saturating, and never wraps.

## Timing
- Reset values: state=COLLECT, `cnt`=0, `tmr`=0, `x1..x4`=0, `out_data`=0, `out_err`=0, `start`=0, `out_valid`=0, `busy`=0, `in_ready`=1 in the first post-reset cycle.
- Reset mid-operation aborts immediately. Partial operands are discarded and any pending `out_valid` is dropped.
- `in_ready`, `out_valid`, `start` and `busy` decode from the state register only, with no combinational path from inputs.
- `start` rises in the cycle after the 4th input handshake.
- `out_valid` rises in the cycle after `done` is sampled.
- Minimum operand-to-result latency:
  - 4 input cycles + 1 START + 1 WAIT (`done` in first WAIT cycle) + OUT.
  - `in_ready` returns the cycle after the output handshake.
- Back-pressure: `in_valid` may be held low indefinitely in COLLECT; `out_ready` may be held low indefinitely in OUT. Neither causes loss or duplication.

## Structure
- Shared package `seq_pkg`:
  - State enum (COLLECT, START, WAIT, OUT).
  - `WORD_W`=32, `N_OPS`=4, `TMR_W`=16.
- One sub-module `seq_timer`: clear/enable/saturating counter with `expired` at `TIMEOUT-1`, instantiated for WAIT.
- Operand slots are a 4×32 register array indexed by `cnt`.

## Test plan
- Feed 5, 9, 2, 7 back-to-back, `done` with `result`=0x9 three cycles after `start` -> `x1..x4`=5,9,2,7; `start` one cycle after the 4th handshake; `out_data`=0x9, `out_err`=0.
- Gaps of 3 idle cycles between operands, `out_ready` low for 10 cycles -> operands placed correctly; `out_valid` and `out_data` stay stable until handshake; exactly one output transfer.
- Never assert `done`, TIMEOUT=8 -> `out_valid` 8 cycles after entering WAIT with `out_data`=0, `out_err`=1; next batch then completes normally.
- Assert `done` during COLLECT and in the START cycle -> no state change and no output; only WAIT-cycle `done` completes.
- `rst` after 2 operands, then after entering WAIT, then with `out_valid` pending -> all outputs at reset values next cycle; the following 4-operand batch produces a correct single result.
- `done` and timeout expiry in the same cycle -> `out_err`=0 and `out_data`=`result`.
